// File: rtl/i2c_cmd_tx_sequencer.sv
// i2c_cmd_tx_sequencer
// Sends a three-word command frame (opcode, operand1, operand2) to an I2C
// master core, one 32-bit word per transaction, with a per-word handshake,
// an inter-word gap and a per-transaction timeout.
// Optional feature: define I2C_CMD_TX_RETRY_EN to re-send a NACKed word up
// to MAX_RETRY times before aborting the frame.
module i2c_cmd_tx_sequencer #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] opcode,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        i2c_start,
  output logic [31:0] i2c_tx_data,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic [1:0]  word_idx,
  output logic [2:0]  state_out
);

`ifdef I2C_CMD_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RETRY_LIM = 32'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  state_t      state, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] opd1_q, opd1_d;
  logic [31:0] opd2_q, opd2_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] retry_q, retry_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_sel;

  // Captured word for the current word index
  always_comb begin
    word_sel = '0;
    case (idx_q)
      2'd1:    word_sel = op_q;
      2'd2:    word_sel = opd1_q;
      2'd3:    word_sel = opd2_q;
      default: word_sel = '0;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      opd1_q    <= '0;
      opd2_q    <= '0;
      tx_q      <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      opd1_q    <= opd1_d;
      opd2_q    <= opd2_d;
      tx_q      <= tx_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state and next-datapath logic
  // tx data is loaded on the edge into LOAD so it is valid throughout LOAD,
  // SEND and WAIT; the timeout compares the incremented count so ABORT is
  // entered on the edge where the counter reaches TIMEOUT_CYCLES-1.
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    opd1_d    = opd1_q;
    opd2_d    = opd2_q;
    tx_d      = tx_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          opd1_d  = operand1;
          opd2_d  = operand2;
          tx_d    = opcode;
          idx_d   = 2'd1;
          retry_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (i2c_done) begin
          retry_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_FIN;
          end else begin
            idx_d     = idx_q + 2'd1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end else if (i2c_nack) begin
          if (RETRY_EN && (retry_q < RETRY_LIM)) begin
            retry_d   = retry_q + 32'd1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            state_d = S_ABORT;
          end
        end else if (to_cnt_d == TMO_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          tx_d    = word_sel;
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      S_FIN, S_ABORT: begin
        idx_d   = '0;
        tx_d    = '0;
        op_d    = '0;
        opd1_d  = '0;
        opd2_d  = '0;
        retry_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    i2c_start   = (state == S_SEND);
    frame_done  = (state == S_FIN);
    err         = (state == S_ABORT);
    busy        = (state != S_IDLE);
    i2c_tx_data = tx_q;
    word_idx    = idx_q;
    state_out   = state;
  end

endmodule

// File: tb/tb_i2c_cmd_tx_sequencer.sv
// Self-checking bench for i2c_cmd_tx_sequencer: table of frames with
// scripted responder behaviour, scoreboard of expected words per i2c_start,
// plus hand-written reset-mid-frame sequence.
`timescale 1ns/1ps
module tb_i2c_cmd_tx_sequencer;

  localparam int unsigned GAP  = 16;
  localparam int unsigned TMO  = 50;
  localparam int unsigned MAXR = 2;
`ifdef I2C_CMD_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opcode, operand1, operand2;
  logic        i2c_done, i2c_nack;
  logic        i2c_start;
  logic [31:0] i2c_tx_data;
  logic        busy, frame_done, err;
  logic [1:0]  word_idx;
  logic [2:0]  state_out;

  i2c_cmd_tx_sequencer #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .operand1   (operand1),
    .operand2   (operand2),
    .i2c_done   (i2c_done),
    .i2c_nack   (i2c_nack),
    .i2c_start  (i2c_start),
    .i2c_tx_data(i2c_tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .word_idx   (word_idx),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef enum int {K_NONE, K_TMO, K_NACK_ALL, K_NACK_ONCE} kind_t;

  typedef struct {
    logic [31:0] op;
    logic [31:0] o1;
    logic [31:0] o2;
    int          fail_word;
    kind_t       kind;
    bit          poke;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_done = 0;
  int   n_err  = 0;

  // Monitor: samples 1ns after the falling edge, after the bench has driven
  logic        prev_start = 1'b0;
  logic [31:0] last_tx    = '0;
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (i2c_start) begin
      chk("start_width", 32'(prev_start), 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_start: got i2c_start with word_idx %0d data 0x%0h, expected none (cycle %0d)",
                 word_idx, i2c_tx_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("tx_data", i2c_tx_data, e.data);
        chk("word_idx", 32'(word_idx), 32'(e.idx));
        chk("busy_in_send", 32'(busy), 32'd1);
      end
      last_tx = i2c_tx_data;
    end
    if ((i2c_done || i2c_nack) && state_out == 3'd3)
      chk("tx_stable_in_wait", i2c_tx_data, last_tx);
    if (frame_done) n_done++;
    if (err) n_err++;
    prev_start = i2c_start;
  end

  function automatic logic [31:0] word_of(input vec_t v, input int w);
    case (w)
      1:       return v.op;
      2:       return v.o1;
      default: return v.o2;
    endcase
  endfunction

  // Responder decision per transfer: 0 = silent, 1 = done, 2 = nack
  function automatic int decide(input vec_t v, input int w, input int attempt);
    if (w != v.fail_word) return 1;
    case (v.kind)
      K_TMO:       return 0;
      K_NACK_ALL:  return 2;
      K_NACK_ONCE: return (attempt == 1) ? 2 : 1;
      default:     return 1;
    endcase
  endfunction

  task automatic run_frame(input vec_t v);
    int  c_start, t_ref, t_start, t_first, cur_word, attempt, resp_cnt, resp_kind, budget;
    bit  first, finished, exp_done;
    n_done   = 0;
    n_err    = 0;
    exp_done = (v.fail_word == 0) || (v.kind == K_NACK_ONCE && RETRY);
    for (int w = 1; w <= 3; w++) begin
      int n;
      bit stop;
      n    = 1;
      stop = 1'b0;
      if (w == v.fail_word) begin
        case (v.kind)
          K_TMO:       stop = 1'b1;
          K_NACK_ALL:  begin n = RETRY ? int'(MAXR) + 1 : 1; stop = 1'b1; end
          K_NACK_ONCE: begin n = RETRY ? 2 : 1; stop = !RETRY; end
          default:     ;
        endcase
      end
      for (int k = 0; k < n; k++) sb.push_back('{data: word_of(v, w), idx: 2'(w)});
      if (stop) break;
    end

    @(negedge clk);
    opcode   = v.op;
    operand1 = v.o1;
    operand2 = v.o2;
    start    = 1'b1;
    c_start  = cyc;
    @(negedge clk);
    // Scramble inputs after capture: only the captured values may be sent
    opcode   = $urandom;
    operand1 = $urandom;
    operand2 = $urandom;

    first    = 1'b1;
    finished = 1'b0;
    cur_word = 0;
    attempt  = 0;
    resp_cnt = -1;
    resp_kind = 0;
    t_ref    = 0;
    t_start  = 0;
    t_first  = 0;
    budget   = 0;
    while (!finished && budget < 2000) begin
      start    = 1'b0;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (i2c_start) begin
        if (first) begin
          chk("lat_start_to_i2c_start", 32'(cyc - c_start), 32'd2);
          t_first = cyc;
        end else begin
          chk("lat_resp_to_i2c_start", 32'(cyc - t_ref), 32'(GAP + 2));
        end
        first   = 1'b0;
        t_start = cyc;
        if (int'(word_idx) == cur_word) attempt++;
        else begin
          cur_word = int'(word_idx);
          attempt  = 1;
        end
        resp_kind = decide(v, cur_word, attempt);
        resp_cnt  = (resp_kind == 1) ? 40 : (resp_kind == 2) ? 7 : -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          if (resp_kind == 1) i2c_done = 1'b1;
          else                i2c_nack = 1'b1;
          t_ref = cyc;
        end
      end
      if (v.poke && !first && cyc == t_first + 5) begin
        start    = 1'b1;
        opcode   = 32'hDEAD_BEEF;
        operand1 = 32'hCAFE_0001;
        operand2 = 32'hCAFE_0002;
      end
      if (frame_done) begin
        chk("state_at_frame_done", 32'(state_out), 32'd5);
        @(negedge clk);
        chk("busy_after_frame_done", 32'(busy), 32'd0);
        finished = 1'b1;
      end else if (err) begin
        chk("state_at_err", 32'(state_out), 32'd6);
        if (v.kind == K_TMO)
          chk("timeout_err_latency", 32'(cyc - t_start), 32'(TMO));
        finished = 1'b1;
      end else begin
        @(negedge clk);
        budget++;
      end
    end
    start    = 1'b0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_end_wait: got no frame_done/err within 2000 cycles, expected one");
    end
    repeat (25) @(negedge clk);
    chk("frame_done_count", 32'(n_done), 32'(exp_done));
    chk("err_count", 32'(n_err), 32'(!exp_done));
    chk("all_words_sent", 32'(sb.size()), 32'd0);
    chk("idle_state", 32'(state_out), 32'd0);
    chk("idle_word_idx", 32'(word_idx), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    sb.delete();
  endtask

  task automatic reset_mid_frame();
    int cnt, after;
    n_done = 0;
    n_err  = 0;
    @(negedge clk);
    opcode   = 32'h0000_0011;
    operand1 = 32'h0000_0022;
    operand2 = 32'h0000_0033;
    start    = 1'b1;
    sb.push_back('{data: 32'h0000_0011, idx: 2'd1});
    cnt   = -1;
    after = -1;
    for (int i = 0; i < 300 && after != 0; i++) begin
      @(negedge clk);
      start    = 1'b0;
      i2c_done = 1'b0;
      if (i2c_start) cnt = 40;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i2c_done = 1'b1;
          after    = 6;
        end
      end else if (after > 0) after--;
    end
    i2c_done = 1'b0;
    if (after != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rst_setup: got no word-1 transfer within 300 cycles, expected one");
    end
    chk("pre_rst_state_gap", 32'(state_out), 32'd4);
    chk("pre_rst_word_idx", 32'(word_idx), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_out), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_word_idx", 32'(word_idx), 32'd0);
    chk("async_rst_tx_data", i2c_tx_data, 32'd0);
    chk("async_rst_pulses", {29'd0, i2c_start, frame_done, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_frame_done", 32'(n_done), 32'd0);
    chk("rst_no_err", 32'(n_err), 32'd0);
    chk("rst_queue_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd2,          32'd7,          32'd6,          0, K_NONE,      1'b0};
    vecs[1] = '{32'hA5A5_0003,  32'h1234_5678,  32'hFFFF_FFFF,  0, K_NONE,      1'b1};
    vecs[2] = '{32'd1,          32'd100,        32'd200,        1, K_TMO,       1'b0};
    vecs[3] = '{32'd3,          32'h0000_BEEF,  32'h0000_F00D,  2, K_NACK_ALL,  1'b0};
    vecs[4] = '{32'd0,          32'h8000_0000,  32'h0000_0001,  2, K_NACK_ONCE, 1'b0};
    vecs[5] = '{32'd2,          32'd9,          32'd8,          3, K_TMO,       1'b0};
    vecs[6] = '{32'd0,          32'd0,          32'd0,          0, K_NONE,      1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    opcode   = '0;
    operand1 = '0;
    operand2 = '0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_word_idx", 32'(word_idx), 32'd0);
    chk("reset_tx_data", i2c_tx_data, 32'd0);
    chk("reset_pulses", {29'd0, i2c_start, frame_done, err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);
    reset_mid_frame();
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
